// File: rtl/sfft_stream_decoder_if.sv
// sfft_stream_decoder_if: bitstream-in / binary-out bundle for the stochastic FFT output decoder
//   master: drives iClr, iEn, iStart, iCont, iReal, iImg, iReady; observes the outputs
//   slave : the decoder side, drives oReal, oImg, oValid, oBusy, oOvf
interface sfft_stream_decoder_if #(
  parameter int NUMINPUTS = 8,
  parameter int BITWIDTH = 8
);
  logic iClr;
  logic iEn;
  logic iStart;
  logic iCont;
  logic iReady;
  logic [NUMINPUTS-1:0] iReal;
  logic [NUMINPUTS-1:0] iImg;
  logic [NUMINPUTS*(BITWIDTH+2)-1:0] oReal;
  logic [NUMINPUTS*(BITWIDTH+2)-1:0] oImg;
  logic oValid;
  logic oBusy;
  logic oOvf;
  modport master (
    output iClr, iEn, iStart, iCont, iReady, iReal, iImg,
    input oReal, oImg, oValid, oBusy, oOvf
  );
  modport slave (
    input iClr, iEn, iStart, iCont, iReady, iReal, iImg,
    output oReal, oImg, oValid, oBusy, oOvf
  );
endinterface

// File: rtl/sfft_stream_decoder.sv
// sfft_stream_decoder: counts ones per lane over a 2^BITWIDTH window and emits signed bipolar results
//   iClk, iRst : clock, synchronous active-high reset
//   bus        : slave side of sfft_stream_decoder_if (controls, bitstreams, results, status)
module sfft_stream_decoder #(
  parameter int NUMINPUTS = 8,
  parameter int BITWIDTH = 8,
  parameter int DROP = 0
) (
  input logic iClk,
  input logic iRst,
  sfft_stream_decoder_if.slave bus
);
  localparam int W = BITWIDTH + 2;
  localparam int AW = BITWIDTH + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DROP = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [7:0] DROP_LAST = 8'(DROP > 0 ? DROP - 1 : 0);
  localparam logic [W-1:0] HALF = W'(2 ** BITWIDTH);
  logic [1:0] state_q, state_d;
  logic [7:0] drop_q, drop_d;
  logic [BITWIDTH-1:0] win_q, win_d;
  logic [NUMINPUTS-1:0][AW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [NUMINPUTS-1:0][W-1:0] res_re_q, res_re_d, res_im_q, res_im_d;
  logic valid_q, valid_d, ovf_q, ovf_d;
  logic sample, last;
  assign sample = bus.iEn && state_q == S_ACCUM;
  assign last = sample && &win_q;
  always_comb begin
    state_d = state_q;
    drop_d = drop_q;
    win_d = win_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    res_re_d = res_re_q;
    res_im_d = res_im_q;
    // a load on the accept edge keeps oValid high and is not an overrun
    valid_d = last || (valid_q && !bus.iReady);
    ovf_d = ovf_q || (last && valid_q && !bus.iReady);
    if (bus.iEn && state_q == S_IDLE && bus.iStart) begin
      state_d = DROP > 0 ? S_DROP : S_ACCUM;
      drop_d = '0;
      win_d = '0;
      acc_re_d = '0;
      acc_im_d = '0;
    end
    if (bus.iEn && state_q == S_DROP) begin
      drop_d = drop_q + 8'd1;
      state_d = drop_q == DROP_LAST ? S_ACCUM : S_DROP;
    end
    if (sample) begin
      win_d = win_q + BITWIDTH'(1);
      state_d = last && !bus.iCont ? S_IDLE : S_ACCUM;
      for (int i = 0; i < NUMINPUTS; i++) begin
        acc_re_d[i] = last ? '0 : acc_re_q[i] + AW'(bus.iReal[i]);
        acc_im_d[i] = last ? '0 : acc_im_q[i] + AW'(bus.iImg[i]);
        // the final bit is folded in here so no sample is lost at the window edge
        res_re_d[i] = last ? {acc_re_q[i] + AW'(bus.iReal[i]), 1'b0} - HALF : res_re_q[i];
        res_im_d[i] = last ? {acc_im_q[i] + AW'(bus.iImg[i]), 1'b0} - HALF : res_im_q[i];
      end
    end
  end
  always_ff @(posedge iClk) begin
    if (iRst || bus.iClr) begin
      state_q <= S_IDLE;
      drop_q <= '0;
      win_q <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      res_re_q <= '0;
      res_im_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q <= drop_d;
      win_q <= win_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      res_re_q <= res_re_d;
      res_im_q <= res_im_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.oReal = res_re_q;
  assign bus.oImg = res_im_q;
  assign bus.oValid = valid_q;
  assign bus.oBusy = state_q != S_IDLE;
  assign bus.oOvf = ovf_q;
endmodule
